// File: rtl/conv_pkg.sv
// Shared defaults and derived widths for the convolution datapath.
// Modules recompute derived values from their own parameters; these are the defaults.
package conv_pkg;

    localparam int unsigned DEFAULT_BITS        = 9;
    localparam int unsigned DEFAULT_KERNEL_SIZE = 3;
    localparam int unsigned DEFAULT_N           = DEFAULT_KERNEL_SIZE * DEFAULT_KERNEL_SIZE;
    localparam int unsigned DEFAULT_ACC_W       = 2 * DEFAULT_BITS + $clog2(DEFAULT_N);

    typedef logic signed [DEFAULT_BITS-1:0] pixel_t;

    localparam int SAT_MAX = (2 ** (DEFAULT_BITS - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DEFAULT_BITS - 1));

endpackage

// File: rtl/kernel_mem.sv
// Serial-load coefficient shift register with saturating load counter and ready flag.
// The first coefficient written ends up in the highest slot after N writes.
module kernel_mem
    import conv_pkg::*;
#(
    parameter int unsigned BITS        = DEFAULT_BITS,
    parameter int unsigned KERNEL_SIZE = DEFAULT_KERNEL_SIZE
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_write_en,
    input  logic [BITS-1:0]                        i_kernel_in,
    output logic                                   o_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] o_kernel
);

    localparam int unsigned N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [N*BITS-1:0] r_kernel;
    logic [CW-1:0]     r_count;
    logic              r_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_kernel <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else if (i_write_en) begin
            r_kernel <= {r_kernel[(N-1)*BITS-1:0], i_kernel_in};
            if (r_count != CNT_FULL) begin
                r_count <= r_count + 1'b1;
            end
            // Sticky: further writes slide the window but never drop ready.
            r_ready <= r_ready | (r_count == CNT_LAST);
        end
    end

    assign o_kernel = r_kernel;
    assign o_ready  = r_ready;

endmodule

// File: rtl/kernel_mac.sv
// Saturated signed dot product of a pixel window with the loaded kernel.
// Uses the registered kernel, so a write on the same edge only affects the next compute.
module kernel_mac
    import conv_pkg::*;
#(
    parameter int unsigned BITS        = DEFAULT_BITS,
    parameter int unsigned KERNEL_SIZE = DEFAULT_KERNEL_SIZE
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   write_en,
    input  logic [BITS-1:0]                        kernel_in,
    output logic                                   ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] kernel_out,
    input  logic                                   out_en,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] shift_in,
    output logic [BITS-1:0]                        pixel_out
);

    localparam int unsigned N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned ACC_W = 2 * BITS + $clog2(N);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (BITS - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (BITS - 1)));

    logic                     w_ready;
    logic [N*BITS-1:0]        w_kernel;
    logic signed [2*BITS-1:0] w_prod [N];
    logic signed [ACC_W-1:0]  w_acc;
    logic [BITS-1:0]          w_sat;
    logic [BITS-1:0]          r_pixel;

    kernel_mem #(
        .BITS        (BITS),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_kernel_mem (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_write_en  (write_en),
        .i_kernel_in (kernel_in),
        .o_ready     (w_ready),
        .o_kernel    (w_kernel)
    );

    for (genvar k = 0; k < N; k++) begin : g_prod
        assign w_prod[k] = (2 * BITS)'($signed(shift_in[k*BITS +: BITS]))
                         * (2 * BITS)'($signed(w_kernel[k*BITS +: BITS]));
    end

    // Accumulator is wide enough that the sum of all products cannot overflow.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N; k++) begin
            w_acc = w_acc + ACC_W'(w_prod[k]);
        end
    end

    always_comb begin
        w_sat = w_acc[BITS-1:0];
        if (w_acc > SAT_HI) begin
            w_sat = SAT_HI[BITS-1:0];
        end else if (w_acc < SAT_LO) begin
            w_sat = SAT_LO[BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pixel <= '0;
        end else if (out_en && w_ready) begin
            r_pixel <= w_sat;
        end
    end

    assign ready      = w_ready;
    assign kernel_out = w_kernel;
    assign pixel_out  = r_pixel;

endmodule

// File: tb/tb_kernel_mac.sv
// Directed and random checks of kernel_mac against an array-based reference model.
module tb_kernel_mac;
    import conv_pkg::*;

    localparam int B  = DEFAULT_BITS;
    localparam int NT = DEFAULT_N;
    localparam int W  = NT * B;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_en;
    logic [B-1:0]  kernel_in;
    logic          ready;
    logic [W-1:0]  kernel_out;
    logic          out_en;
    logic [W-1:0]  shift_in;
    logic [B-1:0]  pixel_out;

    always #5 clk = ~clk;

    kernel_mac #(
        .BITS        (B),
        .KERNEL_SIZE (DEFAULT_KERNEL_SIZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .kernel_in  (kernel_in),
        .ready      (ready),
        .kernel_out (kernel_out),
        .out_en     (out_en),
        .shift_in   (shift_in),
        .pixel_out  (pixel_out)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: kernel slots, write count, ready, output pixel.
    int km [NT];
    int sh [NT];
    int cnt;
    bit rdy;
    int pix;
    // Stimulus for the next edge.
    int kin;
    bit we, oe, rn;

    function automatic int sat(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic logic [W-1:0] pack(input int a [NT]);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < NT; k++) r[k*B +: B] = B'(a[k]);
        return r;
    endfunction

    task automatic step();
        int acc;
        reset     = rn;
        write_en  = we;
        kernel_in = B'(kin);
        out_en    = oe;
        shift_in  = pack(sh);
        @(posedge clk);
        #1;
        if (!rn) begin
            for (int k = 0; k < NT; k++) km[k] = 0;
            cnt = 0;
            rdy = 1'b0;
            pix = 0;
        end else begin
            if (oe && rdy) begin
                acc = 0;
                for (int k = 0; k < NT; k++) acc += sh[k] * km[k];
                pix = sat(acc);
            end
            if (we) begin
                for (int k = NT - 1; k > 0; k--) km[k] = km[k-1];
                km[0] = kin;
                if (cnt < NT) cnt++;
                rdy = (cnt == NT);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [B-1:0] pexp;
        pexp = B'(pix);
        chk({tag, "_ready"}, W'(ready), W'(rdy));
        chk({tag, "_kernel"}, kernel_out, pack(km));
        chk({tag, "_pixel"}, W'(pixel_out), W'(pexp));
    endtask

    task automatic do_reset();
        rn = 1'b0;
        step();
        rn = 1'b1;
    endtask

    task automatic load_uniform(input int v);
        we  = 1'b1;
        kin = v;
        for (int i = 0; i < NT; i++) step();
        we = 1'b0;
    endtask

    task automatic set_shift(input int v);
        for (int k = 0; k < NT; k++) sh[k] = v;
    endtask

    task automatic compute(input string tag);
        oe = 1'b1;
        step();
        oe = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rn = 1'b0; we = 1'b0; oe = 1'b0; kin = 0;
        set_shift(0);
        for (int k = 0; k < NT; k++) km[k] = 0;
        cnt = 0; rdy = 1'b0; pix = 0;

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check_all("idle");
        chk("idle_kernel_zero", kernel_out, '0);

        // Ready timing with 0x0FF writes.
        do_reset();
        we = 1'b1; kin = 'h0FF;
        for (int i = 0; i < NT; i++) begin
            step();
            if (i == NT - 2) chk("ready_after_8", W'(ready), W'(1'b0));
            if (i == NT - 1) chk("ready_after_9", W'(ready), W'(1'b1));
        end
        we = 1'b0;
        check_all("load_ff");

        // Reset mid-load with write_en and out_en asserted.
        do_reset();
        we = 1'b1; kin = 'h0FF;
        for (int i = 0; i < 4; i++) step();
        oe = 1'b1; rn = 1'b0;
        step();
        rn = 1'b1; we = 1'b0; oe = 1'b0;
        check_all("midload_rst");
        chk("midload_kernel_zero", kernel_out, '0);

        // Ordered load 1..9 then a sliding 10th write.
        do_reset();
        we = 1'b1;
        for (int i = 1; i <= NT; i++) begin
            kin = i;
            step();
        end
        check_all("seq9");
        chk("seq9_slot8", W'(kernel_out[8*B +: B]), W'(1));
        chk("seq9_slot0", W'(kernel_out[0 +: B]), W'(9));
        kin = 10;
        step();
        we = 1'b0;
        check_all("seq10");
        chk("seq10_slot0", W'(kernel_out[0 +: B]), W'(10));
        chk("seq10_slot8", W'(kernel_out[8*B +: B]), W'(2));

        // Ready low: out_en must not update the output.
        do_reset();
        set_shift(5);
        compute("notready");

        // Basic dot products.
        load_uniform(1);
        set_shift(1);
        compute("ones");
        chk("ones_const", W'(pixel_out), W'(9));
        set_shift(0);
        compute("zeros");
        set_shift(1);
        step();
        check_all("hold");

        // Saturation corners.
        do_reset();
        load_uniform(255);
        set_shift(255);
        compute("pos_sat");
        do_reset();
        load_uniform(-256);
        set_shift(-256);
        compute("negneg_sat");
        do_reset();
        load_uniform(1);
        set_shift(-256);
        compute("neg_sat");
        chk("neg_sat_const", W'(pixel_out), W'(9'h100));

        // Single tap: slot 0 = -1, rest 0.
        do_reset();
        load_uniform(0);
        kin = -1; we = 1'b1;
        step();
        we = 1'b0;
        set_shift(0);
        sh[0] = 5;
        compute("single_tap");

        // Simultaneous write and compute uses the pre-edge kernel.
        set_shift(3);
        we = 1'b1; kin = 100;
        compute("wr_and_compute");
        we = 1'b0;

        // Random traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            rn  = ($urandom_range(0, 29) != 0);
            we  = $urandom_range(0, 1) != 0;
            oe  = $urandom_range(0, 1) != 0;
            kin = int'($urandom_range(0, 511)) - 256;
            for (int k = 0; k < NT; k++) sh[k] = int'($urandom_range(0, 511)) - 256;
            step();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_mac.md
Name: kernel_mac

Overview:
- Convolution datapath core: holds a KERNEL_SIZE x KERNEL_SIZE signed coefficient kernel, loaded serially one coefficient per clock.
- Computes the saturated signed dot product of a parallel pixel window with that kernel.
- Sits between the image shift register, which supplies shift_in, and the convolve top level, which consumes pixel_out.

Parameters:
- BITS, 9: signed two's-complement width of every pixel, coefficient and result.
- KERNEL_SIZE, 3: kernel edge length; N = KERNEL_SIZE*KERNEL_SIZE taps.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- write_en  in  1  load strobe; one coefficient is accepted per cycle while high.
- kernel_in  in  BITS  serial coefficient input.
- ready  out  1  high once N coefficients have been loaded since reset.
- kernel_out  out  N*BITS  current kernel; slot k occupies bits [k*BITS +: BITS].
- out_en  in  1  compute enable.
- shift_in  in  N*BITS  pixel window; slot k occupies bits [k*BITS +: BITS].
- pixel_out  out  BITS  registered, saturated dot product.

Behaviour:
- Reset (reset==0 at a rising edge) overrides all other inputs, including simultaneous write_en and out_en.
  - All kernel slots clear to 0, the load counter clears to 0, ready=0, pixel_out=0.
  - Reset applied mid-load discards the partial load.
- Load, on a rising edge with write_en=1:
  - Slot k moves to slot k+1 for k=0..N-2; slot N-1 is discarded.
  - kernel_in is written into slot 0.
  - The first coefficient written therefore ends in slot N-1 (MSBs) after N writes.
  - Loading 1..9 in order gives kernel_out slots 8..0 = 1..9 (slot 8 = 1, slot 0 = 9).
- write_en=0: kernel and counter hold.
- Load counter:
  - Saturating; increments per accepted write up to N.
  - ready is registered and goes high on the same edge that accepts the Nth write.
  - ready stays high for further writes, which keep shifting as a sliding window, until reset.
- Compute, on a rising edge with out_en=1 and ready=1:
  - pixel_out <= sat( sum over k of signed(shift_in slot k) * signed(kernel slot k) ).
  - The registered kernel value before the edge is used; a simultaneous write affects the next compute only.
  - Latency: 1 cycle from sampled inputs to pixel_out.
- out_en=0 or ready=0: pixel_out holds.
- Arithmetic:
  - Each product is 2*BITS signed.
  - The accumulator is 2*BITS + ceil(log2 N) bits signed (22 for the defaults), so no internal overflow.
  - sat() clamps to [-2^(BITS-1), 2^(BITS-1)-1] = [-256, 255].
- No X propagation: every register is reset.

Decomposition:
- Shared package conv_pkg holds:
  - BITS and KERNEL_SIZE defaults;
  - derived N and accumulator width;
  - pixel_t typedef (signed [BITS-1:0]);
  - saturation bounds.
- Sub-module kernel_mem: coefficient shift register, load counter and ready.
- The dot product plus saturation stays in kernel_mac as a combinational adder tree feeding the pixel_out register.
- An optional second sub-module, multiplier, may wrap the MAC for reuse.

Test Plan:
- Reset, then write_en=0 for 3 cycles -> kernel_out=0, ready=0, pixel_out=0.
- Reset, then write_en=1 with kernel_in=0x0FF for 9 cycles -> ready=0 after 8 writes and ready=1 exactly after the 9th edge.
  - Reset asserted mid-load at write 5 -> ready=0 and kernel_out=0.
- Reset, then load 1,2,...,9 -> kernel_out slot 8..0 = 1..9.
  - A 10th write of value 10 -> slot 0=10, slot 8=2, ready stays 1.
- Kernel all 1, shift_in all 1, out_en=1 -> pixel_out=9 one cycle later.
  - All-0 shift_in -> pixel_out=0.
  - out_en=0 -> pixel_out holds.
- Kernel all 255, shift_in all 255 -> pixel_out=255 (positive saturation).
  - Kernel all -256, shift_in all -256 -> pixel_out=255 (positive product saturates).
- Kernel all 1, shift_in all -256 -> pixel_out=-256 (negative saturation).
  - Kernel slot 0=-1 and others 0, shift_in slot 0=5 -> pixel_out=-5.
  - ready=0 with out_en=1 -> pixel_out stays 0.
